// File: rtl/inst_fetch_sequencer.sv
// Instruction fetch engine: writable program memory streamed through a
// prefetch FIFO to the controller, with loop passes, abort and done status.
module inst_fetch_sequencer #(
    parameter int INST_WIDTH = 32,
    parameter int IMEM_DEPTH = 256,
    parameter int ADDR_WIDTH = $clog2(IMEM_DEPTH),
    parameter int FIFO_DEPTH = 4,
    parameter int LOOP_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH:0]   instruction_count,
    input  logic [LOOP_WIDTH-1:0] loop_count,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [INST_WIDTH-1:0] wr_data,
    output logic [INST_WIDTH-1:0] inst,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic                  busy,
    output logic                  done,
    output logic [LOOP_WIDTH-1:0] pass_idx
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(IMEM_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [INST_WIDTH-1:0] mem  [IMEM_DEPTH];
    logic [INST_WIDTH-1:0] fifo [FIFO_DEPTH];
    logic [INST_WIDTH-1:0] rd_data;
    logic                  rd_vld_q;
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [PW:0]           occ_q;
    logic [PW+1:0]         fill;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, rd_addr;
    logic [CW-1:0]         cnt_q, cnt_d, cnt_in;
    logic [LOOP_WIDTH-1:0] loop_q, loop_d, pass_q, pass_d;
    logic                  issue, push, pop, done_d, done_q, last;

    assign inst_valid = (occ_q != '0);
    assign inst       = inst_valid ? fifo[rd_ptr_q] : '0;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign pass_idx   = pass_q;

    assign pop  = inst_valid && inst_ready;
    assign push = rd_vld_q;
    assign cnt_in = (instruction_count > DEPTH_C) ? DEPTH_C : instruction_count;

    // A pop this cycle frees a slot for a read issued this cycle.
    assign fill = (PW+2)'(occ_q) + (PW+2)'(rd_vld_q) - (PW+2)'(pop);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        loop_d  = loop_q;
        pass_d  = pass_q;
        done_d  = 1'b0;
        issue   = 1'b0;
        rd_addr = addr_q;
        last    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    if (cnt_in == '0) begin
                        done_d = 1'b1;
                    end else begin
                        issue   = 1'b1;
                        rd_addr = '0;
                        cnt_d   = cnt_in;
                        loop_d  = loop_count;
                        pass_d  = '0;
                        state_d = FETCH;
                    end
                end
            end
            FETCH: issue = (fill < (PW+2)'(FIFO_DEPTH));
            DRAIN: begin
                if (!rd_vld_q && occ_q == (PW+1)'(pop)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (issue) begin
            last = ({1'b0, rd_addr} == cnt_d - CW'(1));
            if (!last) begin
                addr_d = rd_addr + 1'b1;
            end else if (pass_d < loop_d) begin
                addr_d = '0;
                pass_d = pass_d + 1'b1;
            end else begin
                addr_d  = rd_addr;
                state_d = DRAIN;
            end
        end
        if (abort) begin
            state_d = IDLE;
            issue   = 1'b0;
            addr_d  = '0;
            pass_d  = '0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            loop_q   <= '0;
            pass_q   <= '0;
            done_q   <= 1'b0;
            rd_vld_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            loop_q   <= loop_d;
            pass_q   <= pass_d;
            done_q   <= done_d;
            rd_vld_q <= issue;
            if (abort) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                occ_q    <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
                occ_q <= occ_q + (PW+1)'(push) - (PW+1)'(pop);
            end
        end
    end

    // Storage arrays carry no reset; validity lives in the counters above.
    always_ff @(posedge clk) begin
        if (wr_en && state_q == IDLE) mem[wr_addr] <= wr_data;
        if (issue) rd_data <= mem[rd_addr];
        if (push && !abort) fifo[wr_ptr_q] <= rd_data;
    end

endmodule

// File: tb/tb_inst_fetch_sequencer.sv
// Randomized bench for inst_fetch_sequencer against a queue-based
// model of the expected instruction stream.
module tb_inst_fetch_sequencer;

    localparam int DEPTH = 256;
    localparam int AW = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [AW:0] instruction_count = '0;
    logic [7:0]  loop_count = '0;
    logic        wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic        busy;
    logic        done;
    logic [7:0]  pass_idx;

    int checks = 0;
    int failures = 0;
    logic [31:0] mdl [DEPTH];
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    inst_fetch_sequencer dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .instruction_count(instruction_count),
        .loop_count(loop_count),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .inst(inst),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .busy(busy),
        .done(done),
        .pass_idx(pass_idx)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic load(input int a, input logic [31:0] d);
        wr_en = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        mdl[a] = d;
    endtask

    // rdy: percent ready, or -1 for the 1,0,0 pattern.
    // ab_at: abort once this many pops are done (-1 = never).
    task automatic do_run(input int cnt, input int lp, input int rdy,
                          input int ab_at, input bit junk);
        int eff, total, pops, cyc_n, limit;
        bit stall, aborting, fin;
        logic [31:0] held, expv;
        eff = (cnt > DEPTH) ? DEPTH : cnt;
        exp_q.delete();
        for (int p = 0; p <= lp; p++)
            for (int a = 0; a < eff; a++) exp_q.push_back(mdl[a]);
        total = exp_q.size();
        limit = total * 20 + 50;
        pops = 0;
        cyc_n = 0;
        stall = 0;
        fin = 0;
        aborting = 0;
        held = '0;
        instruction_count = 9'(cnt);
        loop_count = 8'(lp);
        while (!fin) begin
            start = (cyc_n == 0);
            aborting = (ab_at >= 0 && pops == ab_at && pops < total);
            abort = aborting;
            if (rdy < 0) inst_ready = (cyc_n % 3 == 2);
            else inst_ready = ($urandom_range(99) < rdy);
            if (aborting) inst_ready = 1'b0;
            wr_en = 1'b0;
            if (junk && cyc_n > 0 && pops < total && !aborting) begin
                wr_en = 1'($urandom_range(1));
                wr_addr = AW'($urandom);
                wr_data = $urandom;
                start = 1'($urandom_range(1));
            end
            @(negedge clk);
            if (cyc_n == 0) begin
                chk("start_valid", inst_valid, 0);
                chk("start_busy", busy, 0);
            end else if (total == 0) begin
                chk("zero_done", done, cyc_n == 1);
                chk("zero_busy", busy, 0);
                if (cyc_n == 2) fin = 1;
            end else begin
                chk("done", done, pops == total);
                chk("busy", busy, pops != total);
                if (cyc_n == 1) chk("lat1", inst_valid, 0);
                if (cyc_n == 2) chk("lat2", inst_valid, 1);
                if (stall) begin
                    chk("hold_valid", inst_valid, 1);
                    chk("hold_inst", inst, held);
                end
                if (pops == total) begin
                    chk("pass_end", pass_idx, lp);
                    if (rdy == 100) chk("thru", cyc_n, total + 2);
                    fin = 1;
                end else if (inst_valid && inst_ready) begin
                    expv = exp_q.pop_front();
                    chk("inst", inst, expv);
                    chk("pass", pass_idx >= (pops / eff) && pass_idx <= lp, 1);
                    pops++;
                end
                stall = inst_valid && !inst_ready;
                held = inst;
            end
            if (!fin && cyc_n > limit) begin
                chk("timeout", 0, 1);
                fin = 1;
            end
            @(posedge clk);
            #1;
            cyc_n++;
            if (aborting && !fin) begin
                abort = 1'b0;
                start = 1'b0;
                wr_en = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    chk("ab_valid", inst_valid, 0);
                    chk("ab_done", done, 0);
                    chk("ab_busy", busy, 0);
                    chk("ab_pass", pass_idx, 0);
                    @(posedge clk);
                    #1;
                end
                fin = 1;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        wr_en = 1'b0;
        inst_ready = 1'b0;
        if (cyc_n > limit) begin
            abort = 1'b1;
            @(posedge clk);
            #1;
            abort = 1'b0;
        end
    endtask

    initial begin
        int cnt, lp, rdy, ab;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_inst", inst, 0);
        chk("rst_valid", inst_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass_idx, 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) load(i, 32'hA0 + 32'(i));
        do_run(5, 0, 100, -1, 0);
        for (int i = 0; i < 3; i++) load(i, 32'hB0 + 32'(i));
        do_run(3, 2, 100, -1, 0);
        for (int i = 0; i < 8; i++) load(i, $urandom);
        do_run(8, 0, -1, -1, 0);
        for (int i = 0; i < 16; i++) load(i, $urandom);
        do_run(16, 0, 100, 4, 0);
        do_run(2, 0, 100, -1, 0);
        do_run(0, 0, 100, -1, 0);
        for (int i = 0; i < DEPTH; i++) load(i, $urandom);
        do_run(256, 0, 100, -1, 0);
        do_run(300, 0, 60, -1, 0);
        do_run(1, 255, 100, -1, 0);
        do_run(8, 1, 70, -1, 1);
        do_run(8, 1, 100, -1, 0);

        instruction_count = 9'd16;
        loop_count = '0;
        start = 1'b1;
        inst_ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_valid", inst_valid, 0);
        chk("arst_inst", inst, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_pass", pass_idx, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("arst_nodone", done, 0);
            chk("arst_idle", busy, 0);
            @(posedge clk);
            #1;
        end
        do_run(4, 0, 100, -1, 0);

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 4; i++) load($urandom_range(DEPTH - 1), $urandom);
            cnt = ($urandom_range(9) == 0) ? $urandom_range(257, 511)
                                           : $urandom_range(0, 20);
            lp = $urandom_range(3);
            rdy = ($urandom_range(2) == 0) ? 100 : $urandom_range(30, 99);
            ab = ($urandom_range(3) == 0) ? $urandom_range(0, 10) : -1;
            do_run(cnt, lp, rdy, ab, 1'($urandom_range(1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
